// File: rtl/rca.sv
// Unsigned ripple-carry adder with a one-cycle registered sum.
// result carries the MSB carry-out in bit SIZE; overflow mirrors it.
module rca_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

module rca #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            in_valid,
  output logic            overflow,
  output logic [SIZE:0]   result,
  output logic            out_valid
);

  logic [SIZE:0]   c;
  logic [SIZE-1:0] s;
  logic [SIZE:0]   sum;

  logic [SIZE:0]   result_d;
  logic [SIZE:0]   result_q;
  logic            overflow_d;
  logic            overflow_q;
  logic            out_valid_d;
  logic            out_valid_q;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < SIZE; i++) begin : g_cell
    rca_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign sum = {c[SIZE], s};

  always_comb begin
    result_d    = result_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      result_d    = sum;
      overflow_d  = c[SIZE];
      out_valid_d = 1'b1;
    end
  end

  // Reset wins over in_valid, so a pair on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rca.sv
// Self-checking bench for rca at SIZE=8 and SIZE=2.
// Expected values come from plain integer addition and spec tables.
module tb_rca;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] a8, b8;
  logic       iv8;
  logic       ovf8;
  logic [8:0] res8;
  logic       vld8;
  logic [1:0] a2, b2;
  logic       iv2;
  logic       ovf2;
  logic [2:0] res2;
  logic       vld2;

  int checks   = 0;
  int failures = 0;

  rca #(.SIZE(8)) u_rca8 (
    .clk       (clk),
    .rst       (rst),
    .a         (a8),
    .b         (b8),
    .in_valid  (iv8),
    .overflow  (ovf8),
    .result    (res8),
    .out_valid (vld8)
  );

  rca #(.SIZE(2)) u_rca2 (
    .clk       (clk),
    .rst       (rst),
    .a         (a2),
    .b         (b2),
    .in_valid  (iv2),
    .overflow  (ovf2),
    .result    (res2),
    .out_valid (vld2)
  );

  task automatic test_reset();
    rst = 1'b1;
    a8 = '1; b8 = '1; iv8 = 1'b1;
    a2 = '1; b2 = '1; iv2 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (res8 !== 9'h0 || ovf8 !== 1'b0 || vld8 !== 1'b0) begin
        failures++;
        $display("FAIL reset8[%0d] got res=%h ovf=%b vld=%b want 000 0 0",
                 i, res8, ovf8, vld8);
      end
      checks++;
      if (res2 !== 3'b0 || ovf2 !== 1'b0 || vld2 !== 1'b0) begin
        failures++;
        $display("FAIL reset2[%0d] got res=%b ovf=%b vld=%b want 000 0 0",
                 i, res2, ovf2, vld2);
      end
    end
    rst = 1'b0;
    iv8 = 1'b0;
    iv2 = 1'b0;
  endtask

  task automatic test_size2_table();
    logic [1:0] ta [10];
    logic [1:0] tb [10];
    logic [2:0] tr [10];
    logic       to [10];
    ta = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b10,
           2'b11, 2'b10, 2'b11, 2'b11, 2'b11};
    tb = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01,
           2'b00, 2'b10, 2'b01, 2'b10, 2'b11};
    tr = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b011,
           3'b011, 3'b100, 3'b100, 3'b101, 3'b110};
    to = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      a2 = ta[i]; b2 = tb[i]; iv2 = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (res2 !== tr[i] || ovf2 !== to[i] || vld2 !== 1'b1) begin
        failures++;
        $display("FAIL add2 %b+%b got res=%b ovf=%b vld=%b want %b %b 1",
                 ta[i], tb[i], res2, ovf2, vld2, tr[i], to[i]);
      end
    end
    iv2 = 1'b0;
  endtask

  task automatic test_ripple8();
    a8 = 8'hFF; b8 = 8'h01; iv8 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (res8 !== 9'h100 || ovf8 !== 1'b1 || vld8 !== 1'b1) begin
      failures++;
      $display("FAIL ripple_ff got res=%h ovf=%b vld=%b want 100 1 1",
               res8, ovf8, vld8);
    end
    a8 = 8'h7F; b8 = 8'h01;
    @(posedge clk); #1;
    checks++;
    if (res8 !== 9'h080 || ovf8 !== 1'b0 || vld8 !== 1'b1) begin
      failures++;
      $display("FAIL ripple_7f got res=%h ovf=%b vld=%b want 080 0 1",
               res8, ovf8, vld8);
    end
    iv8 = 1'b0;
  endtask

  task automatic test_hold();
    a8 = 8'h0F; b8 = 8'h01; iv8 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (res8 !== 9'h010 || ovf8 !== 1'b0 || vld8 !== 1'b1) begin
      failures++;
      $display("FAIL hold_load got res=%h ovf=%b vld=%b want 010 0 1",
               res8, ovf8, vld8);
    end
    iv8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom) | 8'h80;
      @(posedge clk); #1;
      checks++;
      if (res8 !== 9'h010 || ovf8 !== 1'b0 || vld8 !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d] got res=%h ovf=%b vld=%b want 010 0 0",
                 i, res8, ovf8, vld8);
      end
    end
  endtask

  task automatic test_stream_reset();
    logic [7:0] sa [4];
    logic [7:0] sb [4];
    logic [8:0] want;
    for (int i = 0; i < 4; i++) begin
      sa[i] = 8'($urandom) | 8'h01;
      sb[i] = 8'($urandom);
    end
    for (int i = 0; i < 4; i++) begin
      a8 = sa[i]; b8 = sb[i]; iv8 = 1'b1;
      rst = (i == 2);
      @(posedge clk); #1;
      want = (i == 2) ? 9'h0 : 9'(int'(sa[i]) + int'(sb[i]));
      checks++;
      if (res8 !== want || ovf8 !== want[8] || vld8 !== (i != 2)) begin
        failures++;
        $display("FAIL stream[%0d] got res=%h ovf=%b vld=%b want %h %b %b",
                 i, res8, ovf8, vld8, want, want[8], i != 2);
      end
    end
    rst = 1'b0;
    iv8 = 1'b0;
  endtask

  task automatic test_random();
    int         e8 = 0;
    int         e2 = 0;
    bit         ev = 1'b0;
    for (int n = 0; n < 300; n++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      a2 = 2'($urandom); b2 = 2'($urandom);
      iv8 = 1'($urandom); iv2 = iv8;
      rst = ($urandom_range(0, 19) == 0);
      if (rst) begin
        e8 = 0; e2 = 0; ev = 1'b0;
      end else if (iv8) begin
        e8 = int'(a8) + int'(b8);
        e2 = int'(a2) + int'(b2);
        ev = 1'b1;
      end else begin
        ev = 1'b0;
      end
      @(posedge clk); #1;
      checks++;
      if (res8 !== 9'(e8) || ovf8 !== (e8 > 255) || vld8 !== ev) begin
        failures++;
        $display("FAIL rand8[%0d] got res=%h ovf=%b vld=%b want %h %b %b",
                 n, res8, ovf8, vld8, 9'(e8), e8 > 255, ev);
      end
      checks++;
      if (res2 !== 3'(e2) || ovf2 !== (e2 > 3) || vld2 !== ev) begin
        failures++;
        $display("FAIL rand2[%0d] got res=%b ovf=%b vld=%b want %b %b %b",
                 n, res2, ovf2, vld2, 3'(e2), e2 > 3, ev);
      end
    end
    rst = 1'b0;
    iv8 = 1'b0;
    iv2 = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    a8 = '0; b8 = '0; iv8 = 1'b0;
    a2 = '0; b2 = '0; iv2 = 1'b0;
    @(negedge clk);
    test_reset();
    test_size2_table();
    test_ripple8();
    test_hold();
    test_stream_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rca.md
# rca

Parameterised unsigned ripple-carry adder for the ALU datapath. It adds two SIZE-bit operands through a chain of full-adder cells, with carry-in tied to 0. The result is presented as a SIZE+1-bit registered sum plus a separate carry-out (overflow) flag. It is the adder primitive used by the 8-bit ALU and by narrower test instances (for example SIZE=2).

## Interface
- SIZE, default 8, operand width in bits; legal range SIZE >= 1.

Port order for positional instantiation is clk, rst, a, b, in_valid, overflow, result, out_valid.

- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset; synchronous, active-high.
- a  input  SIZE  operand A, unsigned.
- b  input  SIZE  operand B, unsigned.
- in_valid  input  1  qualifies a/b on the current clk edge.
- overflow  output  1  registered carry-out of the MSB cell; always equals result[SIZE].
- result  output  SIZE+1  registered unsigned sum a+b; bit SIZE is the carry-out.
- out_valid  output  1  high for one cycle per accepted operand pair.

## Operation
- The datapath is SIZE full-adder cells chained LSB to MSB, instantiated with a generate loop.
  - Cell i: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]).
  - c[0] = 0.
- Combinational sum = {c[SIZE], s[SIZE-1:0]}, which is exactly a+b with no truncation.
- overflow = c[SIZE].
  - This is unsigned carry-out, not two's-complement overflow.
  - Example: 2'b11+2'b11 gives overflow=1 even though the signed result (-2) is representable.
- Output register:
  - On a clk edge with rst=0 and in_valid=1: result <= sum, overflow <= c[SIZE], out_valid <= 1.
  - On a clk edge with rst=0 and in_valid=0: result and overflow hold their previous values; out_valid <= 0.
- Reset values: result = 0, overflow = 0, out_valid = 0.
- rst has priority over in_valid on the same edge. An operand pair presented on a reset edge is discarded.
- No back-pressure exists: a new operand pair may be accepted every cycle.
- X/Z on a or b propagates; it is not masked.

## Timing
- Latency is 1 cycle. Operands sampled at edge N appear on result/overflow/out_valid after edge N, and are valid through edge N+1.
- Throughput is one addition per cycle.
- Critical path is the full SIZE-cell carry ripple from a[0]/b[0] to c[SIZE], followed by register setup. No lookahead is used.
- Reset mid-stream: the cycle after a reset edge shows out_valid=0 and result=0, regardless of any prior in-flight sample.
- Back-to-back valid inputs produce back-to-back out_valid pulses, one per input, in order.
- overflow and result[SIZE] are always identical on every cycle, including during reset.

## Test plan
- Reset: hold rst=1 for 2 cycles with a=b=all ones and in_valid=1. Required: result=0, overflow=0, out_valid=0 after each edge.
- SIZE=2 no-carry cases, each with in_valid=1 and checked one cycle later:
  - 00+00 -> result=3'b000, overflow=0.
  - 01+00 -> 3'b001, 0.
  - 00+01 -> 3'b001, 0.
  - 10+00 -> 3'b010, 0.
  - 10+01 -> 3'b011, 0.
  - 11+00 -> 3'b011, 0.
- SIZE=2 carry cases:
  - 10+10 -> result=3'b100, overflow=1.
  - 11+01 -> 3'b100, 1.
  - 11+10 -> 3'b101, 1.
  - 11+11 -> 3'b110, 1.
- SIZE=8 full ripple: first 8'hFF+8'h01 -> result=9'h100, overflow=1. Then 8'h7F+8'h01 -> 9'h080, overflow=0, confirming unsigned carry semantics.
- Hold behaviour: after 8'h0F+8'h01 (result=9'h010), drive in_valid=0 and change a/b for 3 cycles. Required: result stays 9'h010, overflow stays 0, out_valid=0.
- Streaming plus mid-stream reset: issue 4 consecutive valid pairs and assert rst on the 3rd edge. Required: outputs 1 and 2 are correct, the 3rd edge yields out_valid=0 and result=0, and the 4th pair is summed normally.
